vend_session_arbiter: RTL and testbench
=======================================

Name: vend_session_arbiter

Overview:
Controller that shares one vending credit accumulator between two coin-feeding buyers. It grants the machine to one requester at a time (round-robin), collects coins from the granted buyer through a valid/ready handshake, and sequences the sale: vend plus change when credit reaches the price, or a full refund on abort or timeout. It sits between the buyer-side coin sources (memory-driven coin feeders) and the vend/dispense outputs.

Parameters:
PRICE, 40, product price in coin units.
COIN_W, 5, coin value width.
CREDIT_W, 7, credit/change width; must hold (PRICE-1)+(2^COIN_W-1); default max 39+31=70.
TIMEOUT, 15, idle cycles in COLLECT before a forced refund; 1..255.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  2  per-buyer session request, level; bit i = buyer i
coin0  in  COIN_W  buyer 0 coin value
coin1  in  COIN_W  buyer 1 coin value
coin_valid  in  2  per-buyer coin valid
coin_ready  out  2  per-buyer coin ready; only the granted bit can be 1
grant  out  2  one-hot owner of the machine, 0 when idle
credit  out  CREDIT_W  current accumulated credit
vend  out  1  one-cycle dispense pulse
refund  out  1  one-cycle refund pulse
change  out  CREDIT_W  amount returned, valid with change_valid
change_valid  out  1  one-cycle strobe; coincides with vend or refund
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, grant=0, coin_ready=0, credit=0, vend=0, refund=0, change=0, change_valid=0, busy=0, timer=0, last_served=1 (buyer 0 wins the first tie).
- All outputs are registered. Only coin_ready is decoded from the state register plus grant.
- States: IDLE, COLLECT, VEND, REFUND.
- IDLE:
  - req=0: stay.
  - One req bit set: grant that buyer.
  - Both set: grant the buyer != last_served.
  - Next cycle: state=COLLECT, grant registered, credit=0, timer=0.
- COLLECT:
  - coin_ready[g]=1 for granted g; the other ready bit is 0.
  - Accept when coin_valid[g]&coin_ready[g]: credit <= credit+coin_g (full CREDIT_W width, never wraps by construction).
  - Accepted nonzero coin: timer <= 0. Coin value 0 is accepted, adds nothing, and does not clear the timer.
  - coin_valid of the non-granted buyer is ignored; that buyer's coin is not consumed.
  - credit+coin_g >= PRICE on an accepted coin: next state=VEND.
  - Else if req[g] drops: next state=REFUND. This is checked before the timer; a coin accepted the same cycle still counts toward the refund.
  - Else timer increments; timer reaching TIMEOUT-1 with no accept: next state=REFUND.
- VEND: one cycle.
  - vend=1, change_valid=1, change=credit-PRICE, coin_ready=0.
  - last_served <= g; next state=IDLE with grant=0, credit=0.
- REFUND: one cycle.
  - refund=1, change_valid=1, change=credit (may be 0), coin_ready=0.
  - last_served <= g; next state=IDLE.
- Back-to-back sessions: IDLE is held at least one cycle between sessions. With both req held continuously, grants alternate 0,1,0,1.
- change holds its last value between strobes; consumers sample only on change_valid.
- Reset asserted mid-session: immediate return to reset values. No vend/refund pulse; credit is lost by design.

Decomposition:
- Shared package vend_pkg:
  - state encoding localparams (IDLE=2'd0, COLLECT=2'd1, VEND=2'd2, REFUND=2'd3);
  - default PRICE, COIN_W and CREDIT_W constants shared with the vending datapath.
- One sub-module, rr_arb2: 2-requester round-robin grant logic (inputs req and last_served; output one-hot grant), combinational. The top registers its result in IDLE.
- Accumulator, timer and FSM stay in the top module.

Test Plan:
- Single buyer, exact price: req=01, coins 5,20,5,10 (one per cycle). credit goes 5,25,30,40. Next cycle vend=1, change=0, grant=01. Then IDLE with grant=00.
- Overpay: coins 20,10,20 (credit 20,30,50). VEND with change=10 and change_valid=1.
- Contention: req=11 held, both buyers pay 40 each time. Grants are 01,10,01 across three sessions. coin_ready[1]=0 while grant=01, and buyer 1's valid coin is not absorbed.
- Timeout: coin 5 accepted, then no valid for TIMEOUT=15 cycles. Refund=1, change=5, no vend. A sequence of zero-value coins alone also times out.
- Abort: coins 10,10, then req[0] drops. Next cycle refund=1, change=20. Buyer 1, if requesting, is granted next.
- Async reset: reset pulled low in COLLECT with credit=25, not aligned to clk. All outputs are 0 immediately, with no vend/refund pulse. After release, buyer 0 wins a tie.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending session controller and its datapath.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  localparam int unsigned PRICE_DEF    = 40;
  localparam int unsigned COIN_W_DEF   = 5;
  localparam int unsigned CREDIT_W_DEF = 7;
  localparam int unsigned TIMEOUT_DEF  = 15;
  localparam int unsigned TIMER_W      = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; the buyer not served last wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_served ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/vend_session_arbiter.sv
// Grants one buyer at a time, accumulates its coins and sequences vend or refund.
module vend_session_arbiter
  import vend_pkg::*;
#(
  parameter int unsigned PRICE    = PRICE_DEF,
  parameter int unsigned COIN_W   = COIN_W_DEF,
  parameter int unsigned CREDIT_W = CREDIT_W_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [COIN_W-1:0]   coin0,
  input  logic [COIN_W-1:0]   coin1,
  input  logic [1:0]          coin_valid,
  output logic [1:0]          coin_ready,
  output logic [1:0]          grant,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic                refund,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_t              state, state_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic                last_served, last_n;
  logic [1:0]          grant_n, arb_grant;
  logic [CREDIT_W-1:0] credit_n, change_n, sum;
  logic [COIN_W-1:0]   coin_g;
  logic                vend_n, refund_n, chv_n, busy_n;
  logic                accept, req_g;

  rr_arb2 u_arb (
    .req         (req),
    .last_served (last_served),
    .grant       (arb_grant)
  );

  assign coin_ready = (state == COLLECT) ? grant : '0;
  assign coin_g     = grant[1] ? coin1 : coin0;
  assign accept     = |(coin_valid & coin_ready);
  assign sum        = credit + CREDIT_W'(coin_g);
  assign req_g      = |(req & grant);

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    credit_n = credit;
    timer_n  = timer;
    last_n   = last_served;
    vend_n   = 1'b0;
    refund_n = 1'b0;
    change_n = change;
    chv_n    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n  = COLLECT;
          grant_n  = arb_grant;
          credit_n = '0;
          timer_n  = '0;
        end
      end
      COLLECT: begin
        if (accept) credit_n = sum;
        // Price first, then abort, then idle timeout; a zero coin does not count as activity.
        if (accept && (sum >= PRICE_C)) begin
          state_n  = VEND;
          vend_n   = 1'b1;
          chv_n    = 1'b1;
          change_n = sum - PRICE_C;
        end else if (!req_g) begin
          state_n  = REFUND;
          refund_n = 1'b1;
          chv_n    = 1'b1;
          change_n = credit_n;
        end else if (accept && (coin_g != '0)) begin
          timer_n = '0;
        end else if (timer == TIMER_LAST) begin
          state_n  = REFUND;
          refund_n = 1'b1;
          chv_n    = 1'b1;
          change_n = credit_n;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      VEND, REFUND: begin
        state_n  = IDLE;
        grant_n  = '0;
        credit_n = '0;
        timer_n  = '0;
        last_n   = grant[1];
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant        <= '0;
      credit       <= '0;
      timer        <= '0;
      last_served  <= 1'b1;
      vend         <= 1'b0;
      refund       <= 1'b0;
      change       <= '0;
      change_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      grant        <= grant_n;
      credit       <= credit_n;
      timer        <= timer_n;
      last_served  <= last_n;
      vend         <= vend_n;
      refund       <= refund_n;
      change       <= change_n;
      change_valid <= chv_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Directed vector table plus hand sequences for timeout, abort, contention and async reset.
module tb_vend_session_arbiter;

  logic       clk, reset;
  logic [1:0] req, coin_valid, coin_ready, grant;
  logic [4:0] coin0, coin1;
  logic [6:0] credit, change;
  logic       vend, refund, change_valid, busy;

  int n_vec  = 0;
  int n_fail = 0;

  vend_session_arbiter #(.PRICE(40), .COIN_W(5), .CREDIT_W(7), .TIMEOUT(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .coin0        (coin0),
    .coin1        (coin1),
    .coin_valid   (coin_valid),
    .coin_ready   (coin_ready),
    .grant        (grant),
    .credit       (credit),
    .vend         (vend),
    .refund       (refund),
    .change       (change),
    .change_valid (change_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [4:0] c0;
    logic [4:0] c1;
    logic [1:0] cv;
    logic [1:0] grant;
    logic [1:0] rdy;
    logic [6:0] credit;
    logic       vend;
    logic       refund;
    logic [6:0] change;
    logic       chv;
    logic       busy;
  } vec_t;

  localparam int NVEC = 21;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".grant"}, grant, 0);
    chk({tag, ".coin_ready"}, coin_ready, 0);
    chk({tag, ".credit"}, credit, 0);
    chk({tag, ".vend"}, vend, 0);
    chk({tag, ".refund"}, refund, 0);
    chk({tag, ".change"}, change, 0);
    chk({tag, ".change_valid"}, change_valid, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask

  task automatic session(input logic [1:0] g, input int idx);
    string t;
    t = $sformatf("cont%0d", idx);
    req = 2'b11;
    coin_valid = 2'b00;
    step();
    chk({t, ".grant"}, grant, g);
    chk({t, ".coin_ready"}, coin_ready, g);
    if (g == 2'b01) begin
      coin0 = 5'd20;
      coin1 = 5'd7;
    end else begin
      coin0 = 5'd7;
      coin1 = 5'd20;
    end
    coin_valid = 2'b11;
    step();
    chk({t, ".credit1"}, credit, 20);
    chk({t, ".coin_ready1"}, coin_ready, g);
    step();
    chk({t, ".vend"}, vend, 1);
    chk({t, ".credit2"}, credit, 40);
    chk({t, ".change"}, change, 0);
    chk({t, ".coin_ready2"}, coin_ready, 0);
    coin_valid = 2'b00;
    step();
    chk({t, ".idle_grant"}, grant, 0);
    chk({t, ".idle_busy"}, busy, 0);
    chk({t, ".idle_vend"}, vend, 0);
  endtask

  function automatic vec_t mk(
    logic [1:0] r, logic [4:0] a, logic [4:0] b, logic [1:0] v,
    logic [1:0] g, logic [1:0] rd, logic [6:0] cr, logic vd, logic rf,
    logic [6:0] ch, logic cvo, logic bz);
    vec_t x;
    x.req = r;   x.c0 = a;       x.c1 = b;     x.cv = v;
    x.grant = g; x.rdy = rd;     x.credit = cr;
    x.vend = vd; x.refund = rf;  x.change = ch;
    x.chv = cvo; x.busy = bz;
    return x;
  endfunction

  initial begin
    reset = 1'b0;
    req = '0;
    coin0 = '0;
    coin1 = '0;
    coin_valid = '0;

    //            req    c0  c1  cv     grant  rdy    cr  vd rf ch  cv bz
    tbl[0]  = mk(2'b01, 0,  0,  2'b00, 2'b01, 2'b01, 0,  0, 0, 0,  0, 1);
    tbl[1]  = mk(2'b01, 5,  0,  2'b01, 2'b01, 2'b01, 5,  0, 0, 0,  0, 1);
    tbl[2]  = mk(2'b01, 20, 0,  2'b01, 2'b01, 2'b01, 25, 0, 0, 0,  0, 1);
    tbl[3]  = mk(2'b01, 5,  0,  2'b01, 2'b01, 2'b01, 30, 0, 0, 0,  0, 1);
    tbl[4]  = mk(2'b01, 10, 0,  2'b01, 2'b01, 2'b00, 40, 1, 0, 0,  1, 1);
    tbl[5]  = mk(2'b00, 0,  0,  2'b00, 2'b00, 2'b00, 0,  0, 0, 0,  0, 0);
    tbl[6]  = mk(2'b01, 0,  0,  2'b00, 2'b01, 2'b01, 0,  0, 0, 0,  0, 1);
    tbl[7]  = mk(2'b01, 20, 0,  2'b01, 2'b01, 2'b01, 20, 0, 0, 0,  0, 1);
    tbl[8]  = mk(2'b01, 10, 0,  2'b01, 2'b01, 2'b01, 30, 0, 0, 0,  0, 1);
    tbl[9]  = mk(2'b01, 20, 0,  2'b01, 2'b01, 2'b00, 50, 1, 0, 10, 1, 1);
    tbl[10] = mk(2'b00, 0,  0,  2'b00, 2'b00, 2'b00, 0,  0, 0, 10, 0, 0);
    tbl[11] = mk(2'b10, 0,  0,  2'b00, 2'b10, 2'b10, 0,  0, 0, 10, 0, 1);
    tbl[12] = mk(2'b10, 9,  31, 2'b11, 2'b10, 2'b10, 31, 0, 0, 10, 0, 1);
    tbl[13] = mk(2'b10, 0,  0,  2'b10, 2'b10, 2'b10, 31, 0, 0, 10, 0, 1);
    tbl[14] = mk(2'b10, 0,  9,  2'b10, 2'b10, 2'b00, 40, 1, 0, 0,  1, 1);
    tbl[15] = mk(2'b00, 0,  0,  2'b00, 2'b00, 2'b00, 0,  0, 0, 0,  0, 0);
    tbl[16] = mk(2'b01, 0,  0,  2'b00, 2'b01, 2'b01, 0,  0, 0, 0,  0, 1);
    tbl[17] = mk(2'b01, 31, 0,  2'b01, 2'b01, 2'b01, 31, 0, 0, 0,  0, 1);
    tbl[18] = mk(2'b01, 8,  0,  2'b01, 2'b01, 2'b01, 39, 0, 0, 0,  0, 1);
    tbl[19] = mk(2'b01, 31, 0,  2'b01, 2'b01, 2'b00, 70, 1, 0, 30, 1, 1);
    tbl[20] = mk(2'b00, 0,  0,  2'b00, 2'b00, 2'b00, 0,  0, 0, 30, 0, 0);

    #12;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      req = tbl[i].req;
      coin0 = tbl[i].c0;
      coin1 = tbl[i].c1;
      coin_valid = tbl[i].cv;
      step();
      chk($sformatf("row%0d.grant", i), grant, tbl[i].grant);
      chk($sformatf("row%0d.coin_ready", i), coin_ready, tbl[i].rdy);
      chk($sformatf("row%0d.credit", i), credit, tbl[i].credit);
      chk($sformatf("row%0d.vend", i), vend, tbl[i].vend);
      chk($sformatf("row%0d.refund", i), refund, tbl[i].refund);
      chk($sformatf("row%0d.change", i), change, tbl[i].change);
      chk($sformatf("row%0d.change_valid", i), change_valid, tbl[i].chv);
      chk($sformatf("row%0d.busy", i), busy, tbl[i].busy);
    end

    // Timeout after one coin of 5
    req = 2'b01;
    coin_valid = 2'b00;
    step();
    chk("to.grant", grant, 1);
    coin0 = 5'd5;
    coin_valid = 2'b01;
    step();
    chk("to.credit", credit, 5);
    coin_valid = 2'b00;
    for (int i = 1; i < 15; i++) begin
      step();
      chk($sformatf("to.wait%0d.refund", i), refund, 0);
    end
    step();
    chk("to.refund", refund, 1);
    chk("to.vend", vend, 0);
    chk("to.change", change, 5);
    chk("to.change_valid", change_valid, 1);
    step();
    chk("to.idle_busy", busy, 0);
    chk("to.idle_refund", refund, 0);

    // Zero-value coins only: still times out
    step();
    chk("tz.grant", grant, 1);
    coin0 = 5'd0;
    coin_valid = 2'b01;
    for (int i = 1; i < 15; i++) begin
      step();
      chk($sformatf("tz.wait%0d.refund", i), refund, 0);
    end
    step();
    chk("tz.refund", refund, 1);
    chk("tz.change", change, 0);
    chk("tz.credit", credit, 0);
    coin_valid = 2'b00;
    step();
    chk("tz.idle_busy", busy, 0);

    // Abort: buyer 0 drops its request after 20, buyer 1 waiting
    step();
    chk("ab.grant", grant, 1);
    coin0 = 5'd10;
    coin_valid = 2'b01;
    step();
    step();
    chk("ab.credit", credit, 20);
    req = 2'b10;
    coin_valid = 2'b00;
    step();
    chk("ab.refund", refund, 1);
    chk("ab.vend", vend, 0);
    chk("ab.change", change, 20);
    step();
    chk("ab.idle_grant", grant, 0);
    step();
    chk("ab.next_grant", grant, 2);

    // Async reset mid-session with credit 25, off the clock edge
    coin1 = 5'd25;
    coin_valid = 2'b10;
    step();
    chk("ar.credit", credit, 25);
    coin_valid = 2'b00;
    #3;
    reset = 1'b0;
    #1;
    chk_all_zero("ar.now");
    step();
    chk_all_zero("ar.held");
    req = 2'b11;
    @(negedge clk);
    reset = 1'b1;

    // Contention: tie resolves to buyer 0 after reset, then alternates
    session(2'b01, 0);
    session(2'b10, 1);
    session(2'b01, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
